t_switch_kary: RTL and testbench
================================

Name: t_switch_kary

Overview:
- Single tree switch node with RADIX child ports and one parent port. It generalises the binary T-switch to any power-of-2 radix, so that k-ary fat-less trees can be assembled.
- Each input port has per-VC input FIFOs. Each output port has per-VC credit counters.
- Arbitration is round-robin and each output is registered.
- It sits at level posl, index posx of a tree topology. Leaf and parent links use the credit-based noc_if signalling (vc_target valid one-hot, packet, vc_credit_gnt) flattened to vectors.

Parameters:
- N, 16, number of leaves; power of RADIX.
- RADIX, 4, children per switch; power of 2, >=2.
- A_W, $clog2(N)+1, address width; MSB set = destined for root/host.
- D_W, 32, payload width.
- VC_W, 2, number of virtual channels.
- VC_FIFO_DEPTH, 4, entries per input VC FIFO; also the initial credit per output VC.
- posl, 0, tree level of this switch (0 = directly above leaves).
- posx, 0, index of this switch within its level.
- FAIR_VC_ARB, 0, 0 = fixed-priority VC select (lowest VC wins); 1 = round-robin VC select.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- c_rx_vc_target  in  RADIX*VC_W  per-child incoming flit valid, one-hot VC
- c_rx_packet  in  RADIX*(A_W+D_W)  per-child incoming packet {addr,data}
- c_rx_vc_credit_gnt  out  RADIX*VC_W  credit return to child
- c_tx_vc_target  out  RADIX*VC_W  per-child outgoing valid, one-hot VC
- c_tx_packet  out  RADIX*(A_W+D_W)  per-child outgoing packet
- c_tx_vc_credit_gnt  in  RADIX*VC_W  credit from child
- u_rx_vc_target / u_rx_packet / u_rx_vc_credit_gnt  in/in/out  VC_W / A_W+D_W / VC_W  parent downward link
- u_tx_vc_target / u_tx_packet / u_tx_vc_credit_gnt  out/out/in  VC_W / A_W+D_W / VC_W  parent upward link
- err_overflow  out  1  sticky: flit arrived on a full VC FIFO
- err_credit  out  1  sticky: credit return beyond VC_FIFO_DEPTH

Behaviour:
- Reset (rst=0 at edge): all FIFOs emptied; credit counters set to VC_FIFO_DEPTH; RR pointers set to 0; every *_vc_target, *_vc_credit_gnt and packet output = 0; err flags cleared. Reset mid-operation discards in-flight flits and does not emit credits for them.
- Ports are indexed 0..RADIX-1 = children, RADIX = parent.
- Routing:
  - span S = RADIX^(posl+1); base B = posx*S.
  - If addr[A_W-1]=1 or addr[A_W-2:0] is outside [B, B+S-1], the flit goes to the parent.
  - Otherwise it goes to child ((addr-B) / RADIX^posl).
  - A flit received on the parent port that routes to the parent is legal; it is sent back up.
- Input: a flit with vc_target bit v set is written to FIFO[port][v] at that edge. If vc_target is not one-hot, it is dropped and err_overflow is set. If the FIFO is full, the flit is dropped and err_overflow is set.
- Eligibility: head of FIFO[p][v] is eligible if non-empty and credit[out][v] > 0.
- VC select: each input picks one eligible VC per cycle (fixed or RR per FAIR_VC_ARB). The RR pointer advances only on a grant.
- Output arbitration: each output grants at most one input per cycle, round-robin starting after the last granted input. Each input pops at most one flit per cycle.
- Grant at edge T:
  - FIFO popped.
  - Output vc_target/packet registered, so they are valid in the cycle after T.
  - credit[out][v] decremented.
  - vc_credit_gnt[v] on that input port is pulsed high for exactly one cycle after T.
- Minimum latency: flit written at edge T appears on the output after edge T+1 (2 cycles, input to output).
- Credits: c/u_tx_vc_credit_gnt[v] increments credit[out][v] at that edge. Simultaneous send and credit return on the same output and VC leaves the count unchanged. A return that would exceed VC_FIFO_DEPTH saturates the counter and sets err_credit.
- With no grant, output vc_target = 0 and packet holds its last value.
- Full throughput: one flit per output per cycle when credits are available.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all *_vc_target=0, all gnt=0, err flags 0; a flit injected 1 cycle after release is accepted normally.
- Down-route (N=16, RADIX=4, posl=0, posx=1): u_rx flit addr=6, VC1 at T -> c_tx[2] vc_target=2'b10 with same packet at T+2; u_rx_vc_credit_gnt=2'b10 pulse at T+2.
- Up-route: child 0 sends addr=9 and addr=5'b10000 -> both leave u_tx in order, 1 cycle apart; a flit sent to addr=4 exits c_tx[0].
- Credit stall: withhold c_tx[1] credits, send 5 flits VC0 to addr 5 -> exactly 4 emitted; 5th emitted 1 cycle after a single c_tx_vc_credit_gnt[1] pulse.
- Contention: children 0,1,3 each send one flit to the parent every cycle -> u_tx grant order 0,1,3,0,1,3; no flit loss over 30 cycles.
- Errors: send 5 flits VC0 on child 2 with its outputs blocked -> err_overflow=1 sticky; extra credit pulse when counter is full -> err_credit=1, counter stays 4.

Source files
------------

// File: rtl/t_switch_kary.sv
// t_switch_kary -- one node of a k-ary tree network.
//
// RADIX child ports (0..RADIX-1) and one parent port (index RADIX) are each
// fed into per-VC input FIFOs. Every output port keeps per-VC credit counters
// toward its downstream receiver. Each input picks one eligible VC per cycle,
// and each output grants one requesting input per cycle round-robin. Output
// flits and credit returns are registered.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   c_rx_vc_target/packet    per-child incoming flit (one-hot VC valid, {addr,data})
//   c_rx_vc_credit_gnt       per-child credit return (one pulse per popped flit)
//   c_tx_vc_target/packet    per-child outgoing flit
//   c_tx_vc_credit_gnt       per-child credit return from the child
//   u_rx_* / u_tx_*          same signals for the parent link
//   err_overflow             sticky: flit dropped (full FIFO or non-one-hot VC)
//   err_credit               sticky: credit returned beyond VC_FIFO_DEPTH
module t_switch_kary #(
   parameter int unsigned N             = 16,
   parameter int unsigned RADIX         = 4,
   parameter int unsigned A_W           = $clog2(N) + 1,
   parameter int unsigned D_W           = 32,
   parameter int unsigned VC_W          = 2,
   parameter int unsigned VC_FIFO_DEPTH = 4,
   parameter int unsigned posl          = 0,
   parameter int unsigned posx          = 0,
   parameter int unsigned FAIR_VC_ARB   = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [RADIX*VC_W-1:0]         c_rx_vc_target,
   input  logic [RADIX*(A_W+D_W)-1:0]    c_rx_packet,
   output logic [RADIX*VC_W-1:0]         c_rx_vc_credit_gnt,
   output logic [RADIX*VC_W-1:0]         c_tx_vc_target,
   output logic [RADIX*(A_W+D_W)-1:0]    c_tx_packet,
   input  logic [RADIX*VC_W-1:0]         c_tx_vc_credit_gnt,
   input  logic [VC_W-1:0]               u_rx_vc_target,
   input  logic [A_W+D_W-1:0]            u_rx_packet,
   output logic [VC_W-1:0]               u_rx_vc_credit_gnt,
   output logic [VC_W-1:0]               u_tx_vc_target,
   output logic [A_W+D_W-1:0]            u_tx_packet,
   input  logic [VC_W-1:0]               u_tx_vc_credit_gnt,
   output logic                          err_overflow,
   output logic                          err_credit
);

   localparam int unsigned P      = RADIX + 1;
   localparam int unsigned PW     = A_W + D_W;
   localparam int unsigned PI_W   = $clog2(P);
   localparam int unsigned VI_W   = (VC_W > 1) ? $clog2(VC_W) : 1;
   localparam int unsigned FI_W   = (VC_FIFO_DEPTH > 1) ? $clog2(VC_FIFO_DEPTH) : 1;
   localparam int unsigned CW     = $clog2(VC_FIFO_DEPTH + 1);
   localparam int unsigned SPAN   = RADIX ** (posl + 1);
   localparam int unsigned BASE   = posx * SPAN;
   localparam int unsigned LVL_SH = $clog2(RADIX) * posl;
   localparam logic [CW-1:0] FULL = CW'(VC_FIFO_DEPTH);

   // unpacked views of the flattened link vectors
   logic [VC_W-1:0]  rx_vc   [P];
   logic [PW-1:0]    rx_pkt  [P];
   logic [VC_W-1:0]  tx_cred [P];

   // state
   logic [PW-1:0]    mem      [P][VC_W][VC_FIFO_DEPTH];
   logic [FI_W-1:0]  wr_ptr   [P][VC_W];
   logic [FI_W-1:0]  rd_ptr   [P][VC_W];
   logic [CW-1:0]    cnt      [P][VC_W];
   logic [CW-1:0]    credit   [P][VC_W];
   logic [VI_W-1:0]  vc_ptr   [P];
   logic [PI_W-1:0]  out_ptr  [P];
   logic [VC_W-1:0]  tx_vc_q  [P];
   logic [PW-1:0]    tx_pkt_q [P];
   logic [VC_W-1:0]  rx_gnt_q [P];
   logic             err_ovf_q;
   logic             err_cred_q;

   // arbitration
   logic [PW-1:0]    head      [P][VC_W];
   logic [PI_W-1:0]  head_port [P][VC_W];
   logic [VC_W-1:0]  elig      [P];
   logic [P-1:0]     req;
   logic [VI_W-1:0]  sel_vc    [P];
   logic [PI_W-1:0]  req_port  [P];
   logic [P-1:0]     og_valid;
   logic [PI_W-1:0]  og_src    [P];
   logic [PW-1:0]    og_pkt    [P];
   logic [VC_W-1:0]  send      [P];
   logic [P-1:0]     in_gnt;
   logic [VC_W-1:0]  pop       [P];
   logic [VC_W-1:0]  push      [P];
   logic             rx_bad;

   // Destination port of an address: children cover [BASE, BASE+SPAN-1],
   // each child owning a block of RADIX^posl leaves; everything else goes up.
   function automatic logic [PI_W-1:0] route(input logic [A_W-1:0] addr);
      int unsigned low;
      low = 32'(addr[A_W-2:0]);
      if (addr[A_W-1] || (low < BASE) || (low >= BASE + SPAN))
         return PI_W'(RADIX);
      return PI_W'((low - BASE) >> LVL_SH);
   endfunction

   // First set bit of el at or after start (wrapping); MSB of result = found.
   function automatic logic [VI_W:0] pick_vc(input logic [VC_W-1:0] el,
                                              input logic [VI_W-1:0] start);
      logic [VI_W:0] r;
      r = '0;
      for (int unsigned i = 0; i < VC_W; i++) begin
         int unsigned k;
         k = (32'(start) + i) % VC_W;
         if (!r[VI_W] && el[k]) r = {1'b1, VI_W'(k)};
      end
      return r;
   endfunction

   function automatic logic [FI_W-1:0] ptr_next(input logic [FI_W-1:0] ptr);
      return (ptr == FI_W'(VC_FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   always_comb begin
      for (int unsigned p = 0; p < RADIX; p++) begin
         rx_vc[p]   = c_rx_vc_target[p*VC_W +: VC_W];
         rx_pkt[p]  = c_rx_packet[p*PW +: PW];
         tx_cred[p] = c_tx_vc_credit_gnt[p*VC_W +: VC_W];
      end
      rx_vc[RADIX]   = u_rx_vc_target;
      rx_pkt[RADIX]  = u_rx_packet;
      tx_cred[RADIX] = u_tx_vc_credit_gnt;
   end

   always_comb begin
      rx_bad   = 1'b0;
      req      = '0;
      og_valid = '0;
      in_gnt   = '0;

      // input side: FIFO heads, eligibility, VC choice, write enables
      for (int unsigned p = 0; p < P; p++) begin
         logic [VI_W:0] pk;
         for (int unsigned v = 0; v < VC_W; v++) begin
            head[p][v]      = mem[p][v][rd_ptr[p][v]];
            head_port[p][v] = route(head[p][v][PW-1 -: A_W]);
            elig[p][v]      = (cnt[p][v] != '0) && (credit[head_port[p][v]][v] != '0);
            push[p][v]      = rx_vc[p][v] && $onehot(rx_vc[p]) && (cnt[p][v] != FULL);
         end
         pk          = pick_vc(elig[p], (FAIR_VC_ARB != 0) ? vc_ptr[p] : '0);
         req[p]      = pk[VI_W];
         sel_vc[p]   = pk[VI_W-1:0];
         req_port[p] = head_port[p][sel_vc[p]];
         // any flit that was presented but not written is a drop
         if ((rx_vc[p] != '0) && (push[p] == '0)) rx_bad = 1'b1;
      end

      // output side: round-robin over inputs requesting this output
      for (int unsigned o = 0; o < P; o++) begin
         og_src[o] = '0;
         for (int unsigned i = 0; i < P; i++) begin
            int unsigned s;
            s = (32'(out_ptr[o]) + i) % P;
            if (!og_valid[o] && req[s] && (req_port[s] == PI_W'(o))) begin
               og_valid[o] = 1'b1;
               og_src[o]   = PI_W'(s);
            end
         end
         og_pkt[o] = head[og_src[o]][sel_vc[og_src[o]]];
         send[o]   = og_valid[o] ? (VC_W'(1) << sel_vc[og_src[o]]) : '0;
         if (og_valid[o]) in_gnt[og_src[o]] = 1'b1;
      end

      for (int unsigned p = 0; p < P; p++)
         pop[p] = in_gnt[p] ? (VC_W'(1) << sel_vc[p]) : '0;
   end

   // FIFO storage needs no reset; emptiness is carried by the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned p = 0; p < P; p++)
            for (int unsigned v = 0; v < VC_W; v++)
               if (push[p][v]) mem[p][v][wr_ptr[p][v]] <= rx_pkt[p];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned p = 0; p < P; p++) begin
            vc_ptr[p]   <= '0;
            out_ptr[p]  <= '0;
            tx_vc_q[p]  <= '0;
            tx_pkt_q[p] <= '0;
            rx_gnt_q[p] <= '0;
            for (int unsigned v = 0; v < VC_W; v++) begin
               wr_ptr[p][v] <= '0;
               rd_ptr[p][v] <= '0;
               cnt[p][v]    <= '0;
               credit[p][v] <= FULL;
            end
         end
         err_ovf_q  <= 1'b0;
         err_cred_q <= 1'b0;
      end else begin
         for (int unsigned p = 0; p < P; p++) begin
            rx_gnt_q[p] <= pop[p];
            if (og_valid[p]) begin
               tx_vc_q[p]  <= send[p];
               tx_pkt_q[p] <= og_pkt[p];
               out_ptr[p]  <= (og_src[p] == PI_W'(P - 1)) ? '0 : og_src[p] + 1'b1;
            end else begin
               tx_vc_q[p]  <= '0;
            end
            if (in_gnt[p] && (FAIR_VC_ARB != 0))
               vc_ptr[p] <= (sel_vc[p] == VI_W'(VC_W - 1)) ? '0 : sel_vc[p] + 1'b1;
            for (int unsigned v = 0; v < VC_W; v++) begin
               if (push[p][v]) wr_ptr[p][v] <= ptr_next(wr_ptr[p][v]);
               if (pop[p][v])  rd_ptr[p][v] <= ptr_next(rd_ptr[p][v]);
               cnt[p][v] <= cnt[p][v] + CW'(push[p][v]) - CW'(pop[p][v]);
               // a return coinciding with a send cancels out
               if (tx_cred[p][v] && !send[p][v]) begin
                  if (credit[p][v] == FULL) err_cred_q   <= 1'b1;
                  else                      credit[p][v] <= credit[p][v] + 1'b1;
               end else if (send[p][v] && !tx_cred[p][v]) begin
                  credit[p][v] <= credit[p][v] - 1'b1;
               end
            end
         end
         if (rx_bad) err_ovf_q <= 1'b1;
      end
   end

   for (genvar g = 0; g < RADIX; g++) begin : g_child
      assign c_tx_vc_target[g*VC_W +: VC_W]     = tx_vc_q[g];
      assign c_tx_packet[g*PW +: PW]            = tx_pkt_q[g];
      assign c_rx_vc_credit_gnt[g*VC_W +: VC_W] = rx_gnt_q[g];
   end

   assign u_tx_vc_target     = tx_vc_q[RADIX];
   assign u_tx_packet        = tx_pkt_q[RADIX];
   assign u_rx_vc_credit_gnt = rx_gnt_q[RADIX];
   assign err_overflow       = err_ovf_q;
   assign err_credit         = err_cred_q;

endmodule

// File: tb/tb_t_switch_kary.sv
// Directed bench for t_switch_kary at N=16, RADIX=4, posl=0, posx=1:
// children 0..3 own leaf addresses 4..7, all other addresses go to the parent.
module tb_t_switch_kary;

   localparam int unsigned PW = 37;

   logic          clk;
   logic          rst;
   logic [7:0]    c_rx_vc_target;
   logic [147:0]  c_rx_packet;
   logic [7:0]    c_rx_vc_credit_gnt;
   logic [7:0]    c_tx_vc_target;
   logic [147:0]  c_tx_packet;
   logic [7:0]    c_tx_vc_credit_gnt;
   logic [1:0]    u_rx_vc_target;
   logic [36:0]   u_rx_packet;
   logic [1:0]    u_rx_vc_credit_gnt;
   logic [1:0]    u_tx_vc_target;
   logic [36:0]   u_tx_packet;
   logic [1:0]    u_tx_vc_credit_gnt;
   logic          err_overflow;
   logic          err_credit;

   // downstream receivers: return a credit for every flit unless blocked,
   // plus any extra pulse requested by the stimulus
   logic [7:0]    c_block, c_extra;
   logic [1:0]    u_block, u_extra;

   int unsigned   n_tests, n_fail;

   t_switch_kary #(.N(16), .RADIX(4), .D_W(32), .VC_W(2), .VC_FIFO_DEPTH(4),
                   .posl(0), .posx(1), .FAIR_VC_ARB(0)) dut (
      .clk(clk), .rst(rst),
      .c_rx_vc_target(c_rx_vc_target), .c_rx_packet(c_rx_packet),
      .c_rx_vc_credit_gnt(c_rx_vc_credit_gnt),
      .c_tx_vc_target(c_tx_vc_target), .c_tx_packet(c_tx_packet),
      .c_tx_vc_credit_gnt(c_tx_vc_credit_gnt),
      .u_rx_vc_target(u_rx_vc_target), .u_rx_packet(u_rx_packet),
      .u_rx_vc_credit_gnt(u_rx_vc_credit_gnt),
      .u_tx_vc_target(u_tx_vc_target), .u_tx_packet(u_tx_packet),
      .u_tx_vc_credit_gnt(u_tx_vc_credit_gnt),
      .err_overflow(err_overflow), .err_credit(err_credit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      c_tx_vc_credit_gnt = '0;
      u_tx_vc_credit_gnt = '0;
      forever begin
         @(negedge clk);
         c_tx_vc_credit_gnt = (c_tx_vc_target & ~c_block) | c_extra;
         u_tx_vc_credit_gnt = (u_tx_vc_target & ~u_block) | u_extra;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c_rx_vc_target = '0;
      u_rx_vc_target = '0;
   endtask

   task automatic send_child(input int c, input logic [1:0] vc, input logic [4:0] addr,
                             input logic [31:0] data);
      c_rx_vc_target[c*2 +: 2] = vc;
      c_rx_packet[c*PW +: PW]  = {addr, data};
   endtask

   function automatic logic [36:0] ctx_pkt(input int c);
      return c_tx_packet[c*PW +: PW];
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_vc"}, {c_tx_vc_target, u_tx_vc_target, c_rx_vc_credit_gnt,
                           u_rx_vc_credit_gnt, err_overflow, err_credit}, '0);
      check({tag, "_pkt"}, 64'(|{c_tx_packet, u_tx_packet}), 0);
   endtask

   int n;
   int ccred [4];
   int sent [4];
   int exp_seq [4];
   int rcv, total_sent, bad_seq, c_emits;
   int ord [$];
   int exp_ord [6] = '{0, 1, 3, 0, 1, 3};

   initial begin
      n_tests = 0; n_fail = 0;
      c_block = '0; c_extra = '0; u_block = '0; u_extra = '0;
      c_rx_packet = '0; u_rx_packet = '0;
      idle_inputs();

      // reset held 3 cycles under random input activity
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         c_rx_vc_target = 8'($urandom);
         u_rx_vc_target = 2'($urandom);
         for (int c = 0; c < 4; c++) c_rx_packet[c*PW +: PW] = 37'({$urandom, $urandom});
         u_rx_packet = 37'({$urandom, $urandom});
         step();
         check_quiet("rst");
      end
      idle_inputs();
      rst = 1'b1;
      step();

      // down-route from the parent: addr 6 VC1 -> child 2
      u_rx_vc_target = 2'b10;
      u_rx_packet    = {5'd6, 32'hA5A5_0001};
      step();
      idle_inputs();
      check("down_lat", c_tx_vc_target, 8'h00);
      step();
      check("down_vc",  c_tx_vc_target, 8'h20);
      check("down_pkt", ctx_pkt(2), {5'd6, 32'hA5A5_0001});
      check("down_gnt", u_rx_vc_credit_gnt, 2'b10);
      step();
      check("down_pulse", {c_tx_vc_target, u_rx_vc_credit_gnt}, 0);

      // up-route from child 0: addr 9 then addr 16, back to back
      send_child(0, 2'b01, 5'd9, 32'h0000_0009);
      step();
      send_child(0, 2'b01, 5'b10000, 32'h0000_0010);
      step();
      idle_inputs();
      check("up1_vc",  u_tx_vc_target, 2'b01);
      check("up1_pkt", u_tx_packet, {5'd9, 32'h0000_0009});
      step();
      check("up2_vc",  u_tx_vc_target, 2'b01);
      check("up2_pkt", u_tx_packet, {5'b10000, 32'h0000_0010});
      step();
      check("up_idle", u_tx_vc_target, 2'b00);

      // child 0 to addr 4 stays local on child 0
      send_child(0, 2'b01, 5'd4, 32'h0000_0004);
      step();
      idle_inputs();
      step();
      check("loc_vc",  c_tx_vc_target, 8'h01);
      check("loc_pkt", ctx_pkt(0), {5'd4, 32'h0000_0004});

      // credit stall: child 1 returns no credits, 5 flits VC0 to addr 5
      c_block = 8'h0C;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (i < 5) begin
            u_rx_vc_target = 2'b01;
            u_rx_packet    = {5'd5, 32'(32'h100 + i)};
         end else begin
            u_rx_vc_target = '0;
         end
         step();
         if (c_tx_vc_target[3:2] != 2'b00) begin
            check("stall_data", ctx_pkt(1), {5'd5, 32'(32'h100 + n)});
            n++;
         end
      end
      check("stall_cnt", n, 4);
      c_extra = 8'h04;
      step();
      c_extra = '0;
      check("stall_wait", c_tx_vc_target[3:2], 2'b00);
      step();
      check("stall_5th_vc",  c_tx_vc_target[3:2], 2'b01);
      check("stall_5th_pkt", ctx_pkt(1), {5'd5, 32'h104});
      step();
      check("stall_after", c_tx_vc_target[3:2], 2'b00);

      // overflow: child 2 sends 5 flits toward the blocked child 1
      for (int i = 0; i < 5; i++) begin
         send_child(2, 2'b01, 5'd5, 32'(32'h200 + i));
         step();
         if (i == 3) check("ovf_pre", err_overflow, 0);
      end
      idle_inputs();
      check("ovf_set", err_overflow, 1);
      repeat (3) step();
      check("ovf_sticky", err_overflow, 1);
      check("ovf_blocked", {c_tx_vc_target[3:2], c_rx_vc_credit_gnt[5:4]}, 0);

      // excess credit on child 3 VC1 (counter already full)
      check("crd_pre", err_credit, 0);
      c_extra = 8'h80;
      step();
      c_extra = '0;
      check("crd_set", err_credit, 1);
      c_block = 8'hCC;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (i < 5) begin
            u_rx_vc_target = 2'b10;
            u_rx_packet    = {5'd7, 32'(32'h300 + i)};
         end else begin
            u_rx_vc_target = '0;
         end
         step();
         if (c_tx_vc_target[7:6] != 2'b00) n++;
      end
      check("crd_sat_cnt", n, 4);
      check("crd_sticky", err_credit, 1);

      // reset mid-operation: stuck flits must vanish, flags clear
      rst = 1'b0;
      idle_inputs();
      c_block = '0;
      step();
      rst = 1'b1;
      check_quiet("rst2");
      c_emits = 0;
      repeat (3) begin
         step();
         if (c_tx_vc_target != '0) c_emits++;
      end

      // contention: children 0,1,3 stream to the parent under credit control
      for (int c = 0; c < 4; c++) begin
         ccred[c] = 4; sent[c] = 0; exp_seq[c] = 0;
      end
      rcv = 0; bad_seq = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         for (int c = 0; c < 4; c++) begin
            if (c != 2 && cyc < 30 && ccred[c] > 0) begin
               send_child(c, 2'b01, 5'b10000, {8'(c), 24'(sent[c])});
               ccred[c]--;
               sent[c]++;
            end else begin
               c_rx_vc_target[c*2 +: 2] = 2'b00;
            end
         end
         step();
         for (int c = 0; c < 4; c++)
            if (c_rx_vc_credit_gnt[c*2]) ccred[c]++;
         if (c_tx_vc_target != '0) c_emits++;
         if (u_tx_vc_target != 2'b00) begin
            int s;
            s = int'(u_tx_packet[31:24]);
            if (ord.size() < 6) ord.push_back(s);
            if (s > 3 || int'(u_tx_packet[23:0]) != exp_seq[s & 3]) bad_seq++;
            exp_seq[s & 3]++;
            rcv++;
         end
      end
      idle_inputs();
      total_sent = sent[0] + sent[1] + sent[3];
      for (int i = 0; i < 6; i++)
         check($sformatf("cont_ord%0d", i), (i < ord.size()) ? ord[i] : -1, exp_ord[i]);
      check("cont_total", rcv, total_sent);
      check("cont_seq", bad_seq, 0);
      check("cont_err", {err_overflow, err_credit}, 0);
      check("rst2_discard", c_emits, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
